connect6_empty_scanner: RTL and testbench

Streaming, parametrised successor to the 6-cell empty-slot priority encoder. It accepts one occupancy vector of WIDTH cells and emits the index of every empty cell, one per handshake, in a run-time-selected priority order (highest index first or lowest first). It sits between the board-window fetch logic and the move-candidate generator, so a full row or window is enumerated without software re-masking.

---
 rtl/connect6_pkg.sv | 20 ++
 rtl/connect6_empty_scanner_if.sv | 26 ++
 rtl/prio_enc_n.sv | 30 +++
 rtl/connect6_empty_scanner.sv | 127 ++++++++++++
 tb/tb_connect6_empty_scanner.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/connect6_pkg.sv
// Shared types and constants for the connect6 empty-cell scanner.
package connect6_pkg;

  localparam logic CELL_OCC   = 1'b1;
  localparam logic CELL_EMPTY = 1'b0;

  localparam int unsigned MAX_IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    NONE = 2'd2
  } scan_state_e;

  // All-ones index of the given width, reserved to mean "no empty cell".
  function automatic logic [MAX_IDX_W-1:0] none_idx(input int unsigned idx_w);
    return MAX_IDX_W'((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/connect6_empty_scanner_if.sv
// Vector-in / index-stream-out bus of the empty-cell scanner.
interface connect6_empty_scanner_if #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned IDX_W = $clog2(WIDTH + 1)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_cells;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_rank;
  logic             out_last;
  logic             out_none;

  modport master (
    output in_valid, in_cells, in_msb_first, out_ready,
    input  in_ready, out_valid, out_idx, out_rank, out_last, out_none
  );

  modport slave (
    input  in_valid, in_cells, in_msb_first, out_ready,
    output in_ready, out_valid, out_idx, out_rank, out_last, out_none
  );
endinterface

// File: rtl/prio_enc_n.sv
// WIDTH-input priority encoder, selectable direction, with any-set and one-hot-or-zero flags.
module prio_enc_n #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned IDX_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] req,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             onehot0
);

  // Later hits overwrite earlier ones, so scan order picks the winner.
  always_comb begin
    idx = '0;
    if (msb_first) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any     = |req;
  assign onehot0 = ((req & (req - WIDTH'(1))) == '0);

endmodule

// File: rtl/connect6_empty_scanner.sv
// Streams the index of every empty cell of an occupancy vector, one per handshake.
module connect6_empty_scanner
  import connect6_pkg::*;
#(
  parameter int unsigned WIDTH = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  connect6_empty_scanner_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] rank_q, rank_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_none_q, out_none_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_onehot0;
  logic             hs;

  assign hs = out_valid_q & bus.out_ready;

  // Next pending set, rank and state.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    rank_d    = rank_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = ~bus.in_cells;
          dir_d     = bus.in_msb_first;
          rank_d    = '0;
          state_d   = (|(~bus.in_cells)) ? SCAN : NONE;
        end
      end
      SCAN: begin
        if (hs) begin
          pending_d = pending_q & ~(WIDTH'(1) << out_idx_q);
          if (out_last_q) begin
            state_d = IDLE;
            rank_d  = '0;
          end else begin
            rank_d  = rank_q + IDX_W'(1);
          end
        end
      end
      NONE: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
      rank_d    = '0;
    end
  end

  // Encoder looks at the next pending set so the beat can be registered.
  prio_enc_n #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .req       (pending_d),
    .msb_first (dir_d),
    .idx       (enc_idx),
    .any       (enc_any),
    .onehot0   (enc_onehot0)
  );

  always_comb begin
    out_valid_d = 1'b0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    out_none_d  = 1'b0;
    case (state_d)
      SCAN: begin
        out_valid_d = enc_any;
        out_idx_d   = enc_idx;
        out_last_d  = enc_onehot0;
      end
      NONE: begin
        out_valid_d = 1'b1;
        out_idx_d   = IDX_W'(none_idx(IDX_W));
        out_last_d  = 1'b1;
        out_none_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      dir_q       <= 1'b0;
      rank_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dir_q       <= dir_d;
      rank_q      <= rank_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_none_q  <= out_none_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_rank  = rank_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_none  = out_none_q;

endmodule

// File: tb/tb_connect6_empty_scanner.sv
// Directed and randomized checks of connect6_empty_scanner against a list-based model.
module tb_connect6_empty_scanner;

  localparam int unsigned W     = 19;
  localparam int unsigned IDX_W = $clog2(W + 1);
  localparam int          NONE_IDX = (1 << IDX_W) - 1;

  logic clk;
  logic rst_n;
  logic flush;
  int   nchecks;
  int   nerr;

  connect6_empty_scanner_if #(.WIDTH(W)) bus ();

  connect6_empty_scanner #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] cells, input logic dir);
    chk("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid     = 1'b1;
    bus.in_cells     = cells;
    bus.in_msb_first = dir;
    tick();
    bus.in_valid = 1'b0;
    bus.in_cells = '0;
  endtask

  // mode 0: always ready, 1: alternating 1-0-1, 2: random. flush_at < 0 disables flush.
  task automatic collect(input logic [W-1:0] cells, input logic dir, input int mode, input int flush_at);
    int q[$];
    int rank;
    int cyc;
    int hs;
    logic rdy;
    logic [63:0] h_idx, h_rank, h_last;
    for (int k = 0; k < int'(W); k++) begin
      int i;
      i = dir ? int'(W) - 1 - k : k;
      if (cells[i] == 1'b0) q.push_back(i);
    end
    if (q.size() == 0) begin
      chk("none_valid", bus.out_valid, 1);
      chk("none_flag", bus.out_none, 1);
      chk("none_idx", bus.out_idx, NONE_IDX);
      chk("none_last", bus.out_last, 1);
      chk("none_rank", bus.out_rank, 0);
      chk("none_in_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      tick();
      chk("none_done_valid", bus.out_valid, 0);
      chk("none_done_in_ready", bus.in_ready, 1);
      return;
    end
    rank = 0;
    cyc  = 0;
    hs   = 0;
    while (q.size() > 0) begin
      if (cyc > 400) begin
        chk("timeout_beats_left", q.size(), 0);
        break;
      end
      if (flush_at >= 0 && hs == flush_at) begin
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
          tick();
          chk("flush_no_beat", bus.out_valid, 0);
        end
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      chk("beat_valid", bus.out_valid, 1);
      chk("beat_idx", bus.out_idx, q[0]);
      chk("beat_rank", bus.out_rank, rank);
      chk("beat_last", bus.out_last, (q.size() == 1));
      chk("beat_none", bus.out_none, 0);
      chk("beat_in_ready", bus.in_ready, 0);
      h_idx  = bus.out_idx;
      h_rank = bus.out_rank;
      h_last = bus.out_last;
      tick();
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        rank++;
        hs++;
      end else begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_idx", bus.out_idx, h_idx);
        chk("hold_rank", bus.out_rank, h_rank);
        chk("hold_last", bus.out_last, h_last);
      end
    end
    bus.out_ready = 1'b0;
    chk("done_valid", bus.out_valid, 0);
    chk("done_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] v;
    logic d;
    nchecks          = 0;
    nerr             = 0;
    rst_n            = 1'b0;
    flush            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_cells     = '0;
    bus.in_msb_first = 1'b0;
    bus.out_ready    = 1'b0;
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_rank", bus.out_rank, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_none", bus.out_none, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    // 6-cell cases: upper cells held occupied.
    v = {13'h1FFF, 6'b010110};
    send(v, 1'b1);
    collect(v, 1'b1, 0, -1);
    send(v, 1'b0);
    collect(v, 1'b0, 0, -1);

    v = '1;
    send(v, 1'b1);
    collect(v, 1'b1, 0, -1);

    v = '0;
    send(v, 1'b0);
    collect(v, 1'b0, 1, -1);

    // 8-cell flush case then single-beat follow-up.
    v = {11'h7FF, 8'h00};
    send(v, 1'b0);
    collect(v, 1'b0, 0, 3);
    v = {11'h7FF, 8'hFE};
    send(v, 1'b0);
    collect(v, 1'b0, 0, -1);

    for (int n = 0; n < 12; n++) begin
      v = W'($urandom);
      if (n % 3 == 1) v = v | W'($urandom);
      if (n == 7) v = '1;
      d = 1'($urandom_range(0, 1));
      send(v, d);
      collect(v, d, 2, -1);
    end

    // Asynchronous reset in the middle of a scan.
    v = {13'h1FFF, 6'b010110};
    send(v, 1'b1);
    chk("pre_rst_idx", bus.out_idx, 5);
    bus.out_ready = 1'b1;
    tick();
    chk("pre_rst_idx2", bus.out_idx, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_idx", bus.out_idx, 0);
    chk("async_rst_rank", bus.out_rank, 0);
    chk("async_rst_last", bus.out_last, 0);
    chk("async_rst_none", bus.out_none, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_no_beat", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    v = {13'h1FFF, 6'b111110};
    send(v, 1'b1);
    collect(v, 1'b1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
